// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing generator for the VGA colorizer.
// Two free-running counters (h_cnt, v_cnt) advance on pix_en. Every output is a
// registered decode of the count pair *before* the increment, so all published
// signals describe the same pixel and lag the counters by one enabled edge.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_en,
    output logic        horiz_sync,
    output logic        vert_sync,
    output logic        video_on,
    output logic [11:0] pixel_column,
    output logic [11:0] pixel_row,
    output logic        frame_start,
    output logic        line_start
);

    // Timing landmarks, all expressed in 12-bit count space.
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_VIS_END  = 12'(H_ACTIVE);
    localparam logic [11:0] V_VIS_END  = 12'(V_ACTIVE);
    localparam logic [11:0] HS_BEGIN   = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END     = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] VS_BEGIN   = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END     = 12'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic SYNC_ON  = SYNC_POL;
    localparam logic SYNC_OFF = ~SYNC_POL;

    // Counter state.
    logic [11:0] h_cnt_q, h_cnt_d;
    logic [11:0] v_cnt_q, v_cnt_d;

    // Published (registered) outputs.
    logic        hsync_q,       hsync_d;
    logic        vsync_q,       vsync_d;
    logic        video_on_q,    video_on_d;
    logic [11:0] col_q,         col_d;
    logic [11:0] row_q,         row_d;
    logic        frame_start_q, frame_start_d;
    logic        line_start_q,  line_start_d;

    // Decode of the current (pre-increment) count pair.
    logic h_wrap;
    logic v_wrap;
    logic h_visible;
    logic v_visible;
    logic h_in_sync;
    logic v_in_sync;

    // Combinational decode of the count pair that the next enabled edge publishes.
    always_comb begin
        h_wrap    = (h_cnt_q == H_LAST);
        v_wrap    = (v_cnt_q == V_LAST);
        h_visible = (h_cnt_q < H_VIS_END);
        v_visible = (v_cnt_q < V_VIS_END);
        h_in_sync = (h_cnt_q >= HS_BEGIN) && (h_cnt_q < HS_END);
        v_in_sync = (v_cnt_q >= VS_BEGIN) && (v_cnt_q < VS_END);
    end

    // Next-state: counters advance and outputs reload only on enabled edges;
    // the start pulses fall back to 0 on every other clock.
    always_comb begin
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        video_on_d    = video_on_q;
        col_d         = col_q;
        row_d         = row_q;
        frame_start_d = 1'b0;
        line_start_d  = 1'b0;

        if (pix_en) begin
            // Horizontal counter wraps at end of line and carries into the vertical.
            if (h_wrap) begin
                h_cnt_d = 12'd0;
                if (v_wrap) begin
                    v_cnt_d = 12'd0;
                end else begin
                    v_cnt_d = v_cnt_q + 12'd1;
                end
            end else begin
                h_cnt_d = h_cnt_q + 12'd1;
            end

            // Publish the pre-increment pixel; row/column are never masked in blanking.
            hsync_d       = h_in_sync ? SYNC_ON : SYNC_OFF;
            vsync_d       = v_in_sync ? SYNC_ON : SYNC_OFF;
            video_on_d    = h_visible && v_visible;
            col_d         = h_cnt_q;
            row_d         = v_cnt_q;
            line_start_d  = (h_cnt_q == 12'd0);
            frame_start_d = (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);
        end
    end

    // State register; reset wins over pix_en and parks the syncs inactive.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt_q       <= 12'd0;
            v_cnt_q       <= 12'd0;
            hsync_q       <= SYNC_OFF;
            vsync_q       <= SYNC_OFF;
            video_on_q    <= 1'b0;
            col_q         <= 12'd0;
            row_q         <= 12'd0;
            frame_start_q <= 1'b0;
            line_start_q  <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            col_q         <= col_d;
            row_q         <= row_d;
            frame_start_q <= frame_start_d;
            line_start_q  <= line_start_d;
        end
    end

    assign horiz_sync   = hsync_q;
    assign vert_sync    = vsync_q;
    assign video_on     = video_on_q;
    assign pixel_column = col_q;
    assign pixel_row    = row_q;
    assign frame_start  = frame_start_q;
    assign line_start   = line_start_q;

endmodule
